// File: rtl/indev_capture.sv
// Input-device capture: synchronises in_data, queues accepted changes in a FIFO, raises IRQ while data is queued.
// Optional debounce filter enabled by defining INDEV_DEBOUNCE_EN.
module indev_capture #(
  parameter int DEPTH    = 4,
  parameter int DEBOUNCE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic [3:2]  ADD_I,
  input  logic        WE_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        IRQ
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   s1, s2, cur;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          ie, ovf;
  logic          accept, wr_ctrl, flush, pop, full, store;
  logic          unused_bits;

`ifdef INDEV_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE) + 1;
  logic [DW-1:0] dcnt;
  logic          stable;

  // s2 is stable on an edge where it reloads the value it already holds
  assign stable = (s1 == s2);
  assign accept = stable && (s2 != cur) && (dcnt == DW'(DEBOUNCE - 1));

  always_ff @(posedge clk) begin
    if (reset || !stable || accept || (s2 == cur)) dcnt <= '0;
    else                                           dcnt <= dcnt + DW'(1);
  end

  assign unused_bits = ^DAT_I[31:2];
`else
  assign accept      = (s2 != cur);
  assign unused_bits = ^{DAT_I[31:2], 32'(DEBOUNCE)};
`endif

  assign wr_ctrl = WE_I && (ADD_I == 2'd1);
  assign flush   = wr_ctrl && DAT_I[1];
  assign pop     = WE_I && (ADD_I == 2'd2) && (count != '0);
  assign full    = (count == FULL);
  // A pop on the same edge frees the slot, so a full FIFO still accepts
  assign store   = accept && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      cur    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ie     <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      s1 <= in_data;
      s2 <= s1;
      if (accept)  cur <= s2;
      if (wr_ctrl) ie  <= DAT_I[0];
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
      end else begin
        if (pop)             rd_ptr <= rd_ptr + AW'(1);
        if (store)           wr_ptr <= wr_ptr + AW'(1);
        if (accept && !store) ovf   <= 1'b1;
        count <= count + CW'(store) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && store) mem[wr_ptr] <= s2;
  end

  always_comb begin
    DAT_O = '0;
    case (ADD_I)
      2'd0: DAT_O = cur;
      2'd1: DAT_O[0] = ie;
      2'd2: if (count != '0) DAT_O = mem[rd_ptr];
      2'd3: begin
        DAT_O[0]       = (count != '0);
        DAT_O[1]       = ovf;
        DAT_O[8 +: CW] = count;
      end
      default: DAT_O = '0;
    endcase
  end

  assign IRQ = ie && (count != '0);
endmodule
